// File: rtl/countdown_decrementer_if.sv
// Load handshake and status bundle for the countdown timer.
// The master (control unit or bench) drives load/enable/clear; the slave is the counter.
interface countdown_decrementer_if #(
  parameter int WIDTH = 30
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_value;
  logic             enable;
  logic             irq_clear;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             expired;
  logic             irq;

  modport master (
    output load_valid, load_value, enable, irq_clear,
    input  load_ready, count, busy, expired, irq
  );

  modport slave (
    input  load_valid, load_value, enable, irq_clear,
    output load_ready, count, busy, expired, irq
  );
endinterface

// File: rtl/countdown_decrementer.sv
// Loadable down-counter with a one-cycle expired pulse and a sticky irq.
// Optional feature: define AUTO_RELOAD_EN to re-arm from the last loaded value on expiry.
module countdown_decrementer #(
  parameter int WIDTH = 30
) (
  input  logic                    clk,
  input  logic                    reset,
  countdown_decrementer_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_nxt;
  logic             r_expired;
  logic             w_expired_nxt;
  logic             r_irq;
  logic             w_irq_nxt;
  logic             r_busy;
  logic             w_load;

`ifdef AUTO_RELOAD_EN
  logic [WIDTH-1:0] r_reload;
`endif

  // Always able to accept a load; a load simply restarts the count.
  assign w_load = bus.load_valid;

  always_comb begin
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_expired_nxt = 1'b0;
    if (w_load) begin
      w_count_nxt = bus.load_value;
      if (bus.load_value != '0) begin
        w_state_nxt = S_RUN;
      end else begin
        w_state_nxt   = S_DONE;
        w_expired_nxt = 1'b1;
      end
    end else if (r_state == S_RUN && bus.enable) begin
      if (r_count > WIDTH'(1)) begin
        w_count_nxt = r_count - WIDTH'(1);
      end else begin
        // Expiry edge: count reaches 0 and the pulse is registered alongside it.
        w_expired_nxt = 1'b1;
`ifdef AUTO_RELOAD_EN
        if (r_reload != '0) begin
          w_count_nxt = r_reload;
          w_state_nxt = S_RUN;
        end else begin
          w_count_nxt = '0;
          w_state_nxt = S_DONE;
        end
`else
        w_count_nxt = '0;
        w_state_nxt = S_DONE;
`endif
      end
    end
    // A fresh expiry wins over a simultaneous clear.
    if (w_expired_nxt) begin
      w_irq_nxt = 1'b1;
    end else if (bus.irq_clear) begin
      w_irq_nxt = 1'b0;
    end else begin
      w_irq_nxt = r_irq;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_expired <= 1'b0;
      r_irq     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_expired <= w_expired_nxt;
      r_irq     <= w_irq_nxt;
      r_busy    <= (w_state_nxt == S_RUN);
    end
  end

`ifdef AUTO_RELOAD_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_reload <= '0;
    end else if (w_load) begin
      r_reload <= bus.load_value;
    end
  end
`endif

  assign bus.load_ready = 1'b1;
  assign bus.count      = r_count;
  assign bus.busy       = r_busy;
  assign bus.expired    = r_expired;
  assign bus.irq        = r_irq;

endmodule

// File: tb/tb_countdown_decrementer.sv
// Directed bench for countdown_decrementer; AUTO_RELOAD_EN enables the reload scenario.
module tb_countdown_decrementer;
  localparam int W = 30;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  countdown_decrementer_if #(.WIDTH(W)) bus ();

  countdown_decrementer #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    // Held reset state
    n_tests++;
    if ({bus.count, bus.busy, bus.expired, bus.irq, bus.load_ready} !== {30'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_hold: cnt=%0d busy=%b exp=%b irq=%b rdy=%b, want 0 0 0 0 1",
               bus.count, bus.busy, bus.expired, bus.irq, bus.load_ready);
    end
    #4 reset = 1'b1;
    step();
    // Load 0 so expired and irq are set, then reset asynchronously mid-cycle
    bus.load_valid = 1'b1; bus.load_value = 30'd0;
    step();
    bus.load_valid = 1'b0;
    n_tests++;
    if ({bus.expired, bus.irq} !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_pre: exp=%b irq=%b, want 1 1", bus.expired, bus.irq);
    end
    #3 reset = 1'b0;
    #1;
    n_tests++;
    if ({bus.count, bus.busy, bus.expired, bus.irq, bus.load_ready} !== {30'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_async: cnt=%0d busy=%b exp=%b irq=%b rdy=%b, want 0 0 0 0 1",
               bus.count, bus.busy, bus.expired, bus.irq, bus.load_ready);
    end
    #2 reset = 1'b1;
    step();
  endtask

  task automatic test_count_down();
    logic [W-1:0] exp_cnt [4];
    exp_cnt[0] = 30'd3; exp_cnt[1] = 30'd2; exp_cnt[2] = 30'd1; exp_cnt[3] = 30'd0;
    bus.load_valid = 1'b1; bus.load_value = 30'd3; bus.enable = 1'b1;
    step();
    bus.load_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if ({bus.count, bus.expired, bus.busy} !== {exp_cnt[i], (i == 3), (i != 3)}) begin
        n_fail++;
        $display("FAIL countdown[%0d]: cnt=%0d exp=%b busy=%b, want %0d %b %b",
                 i, bus.count, bus.expired, bus.busy, exp_cnt[i], (i == 3), (i != 3));
      end
      if (i < 3) step();
    end
    n_tests++;
    if (bus.irq !== 1'b1) begin
      n_fail++;
      $display("FAIL countdown_irq: irq=%b, want 1", bus.irq);
    end
    step();
    n_tests++;
    if ({bus.count, bus.expired, bus.irq} !== {30'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL countdown_after: cnt=%0d exp=%b irq=%b, want 0 0 1", bus.count, bus.expired, bus.irq);
    end
    bus.irq_clear = 1'b1;
    step();
    bus.irq_clear = 1'b0;
    n_tests++;
    if (bus.irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_clear: irq=%b, want 0", bus.irq);
    end
  endtask

  task automatic test_enable_toggle();
    int  want_cnt;
    logic want_exp;
    bus.load_valid = 1'b1; bus.load_value = 30'd5; bus.enable = 1'b0;
    step();
    bus.load_valid = 1'b0;
    want_cnt = 5;
    for (int i = 0; i < 10; i++) begin
      bus.enable = (i % 2 == 0);
      step();
      want_exp = 1'b0;
      if (i % 2 == 0 && want_cnt > 0) begin
        want_cnt--;
        want_exp = (want_cnt == 0);
      end
      n_tests++;
      if ({bus.count, bus.expired} !== {W'(want_cnt), want_exp}) begin
        n_fail++;
        $display("FAIL toggle[%0d]: cnt=%0d exp=%b, want %0d %b", i, bus.count, bus.expired, want_cnt, want_exp);
      end
    end
    bus.enable = 1'b0;
    bus.irq_clear = 1'b1;
    step();
    bus.irq_clear = 1'b0;
  endtask

  task automatic test_load_priority();
    bus.load_valid = 1'b1; bus.load_value = 30'd4; bus.enable = 1'b1;
    step();
    bus.load_valid = 1'b0;
    step();
    step();
    n_tests++;
    if (bus.count !== 30'd2) begin
      n_fail++;
      $display("FAIL prio_pre: cnt=%0d, want 2", bus.count);
    end
    bus.load_valid = 1'b1; bus.load_value = 30'd10;
    step();
    bus.load_valid = 1'b0;
    n_tests++;
    if ({bus.count, bus.expired, bus.busy} !== {30'd10, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL prio_reload: cnt=%0d exp=%b busy=%b, want 10 0 1", bus.count, bus.expired, bus.busy);
    end
    for (int i = 0; i < 9; i++) step();
    n_tests++;
    if ({bus.count, bus.irq} !== {30'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL prio_at1: cnt=%0d irq=%b, want 1 0", bus.count, bus.irq);
    end
    bus.irq_clear = 1'b1;
    step();
    n_tests++;
    if ({bus.count, bus.expired, bus.irq} !== {30'd0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL set_over_clear: cnt=%0d exp=%b irq=%b, want 0 1 1", bus.count, bus.expired, bus.irq);
    end
    step();
    bus.irq_clear = 1'b0;
    n_tests++;
    if ({bus.expired, bus.irq} !== 2'b00) begin
      n_fail++;
      $display("FAIL clear_after: exp=%b irq=%b, want 0 0", bus.expired, bus.irq);
    end
  endtask

  task automatic test_load_zero();
    bus.load_valid = 1'b1; bus.load_value = 30'd0; bus.enable = 1'b1;
    step();
    bus.load_valid = 1'b0;
    n_tests++;
    if ({bus.count, bus.expired, bus.busy, bus.irq} !== {30'd0, 1'b1, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL zero_load: cnt=%0d exp=%b busy=%b irq=%b, want 0 1 0 1",
               bus.count, bus.expired, bus.busy, bus.irq);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if ({bus.count, bus.expired, bus.busy} !== {30'd0, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL zero_hold[%0d]: cnt=%0d exp=%b busy=%b, want 0 0 0", i, bus.count, bus.expired, bus.busy);
      end
    end
    // A load leaves the sticky irq alone
    bus.load_valid = 1'b1; bus.load_value = 30'd2; bus.enable = 1'b0;
    step();
    bus.load_valid = 1'b0;
    n_tests++;
    if ({bus.count, bus.busy, bus.irq} !== {30'd2, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL load_keeps_irq: cnt=%0d busy=%b irq=%b, want 2 1 1", bus.count, bus.busy, bus.irq);
    end
  endtask

  task automatic test_reset_mid_run();
    bus.enable = 1'b1;
    step();
    n_tests++;
    if (bus.count !== 30'd1) begin
      n_fail++;
      $display("FAIL midrun_pre: cnt=%0d, want 1", bus.count);
    end
    #3 reset = 1'b0;
    #1;
    n_tests++;
    if ({bus.count, bus.busy, bus.expired, bus.irq} !== {30'd0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL midrun_reset: cnt=%0d busy=%b exp=%b irq=%b, want 0 0 0 0",
               bus.count, bus.busy, bus.expired, bus.irq);
    end
    step();
    n_tests++;
    if ({bus.count, bus.expired} !== {30'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL midrun_nopulse: cnt=%0d exp=%b, want 0 0", bus.count, bus.expired);
    end
    #4 reset = 1'b1;
    step();
    n_tests++;
    if ({bus.count, bus.expired, bus.busy} !== {30'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL midrun_idle: cnt=%0d exp=%b busy=%b, want 0 0 0", bus.count, bus.expired, bus.busy);
    end
    bus.enable = 1'b0;
  endtask

`ifdef AUTO_RELOAD_EN
  task automatic test_auto_reload();
    logic [W-1:0] want_cnt [5];
    want_cnt[0] = 30'd2; want_cnt[1] = 30'd1; want_cnt[2] = 30'd2; want_cnt[3] = 30'd1; want_cnt[4] = 30'd2;
    bus.load_valid = 1'b1; bus.load_value = 30'd2; bus.enable = 1'b1;
    step();
    bus.load_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if ({bus.count, bus.expired, bus.busy} !== {want_cnt[i], (i == 2 || i == 4), 1'b1}) begin
        n_fail++;
        $display("FAIL reload[%0d]: cnt=%0d exp=%b busy=%b, want %0d %b 1",
                 i, bus.count, bus.expired, bus.busy, want_cnt[i], (i == 2 || i == 4));
      end
      if (i < 4) step();
    end
    #3 reset = 1'b0;
    #1;
    n_tests++;
    if ({bus.count, bus.expired, bus.busy} !== {30'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reload_reset: cnt=%0d exp=%b busy=%b, want 0 0 0", bus.count, bus.expired, bus.busy);
    end
    #2 reset = 1'b1;
    bus.enable = 1'b0;
    step();
  endtask
`endif

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_value = '0;
    bus.enable     = 1'b0;
    bus.irq_clear  = 1'b0;
    step();
    step();
    test_reset();
    test_count_down();
    test_enable_toggle();
    test_load_priority();
    test_load_zero();
    test_reset_mid_run();
`ifdef AUTO_RELOAD_EN
    test_auto_reload();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
